// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between byte producers, the arbiter and the UART transmitter.
// slave = arbiter side, master = producers/transmitter side.
interface uart_tx_arbiter_if #(
  parameter int NREQ = 4,
  parameter int N    = 8,
  parameter int IDXW = 2
);
  logic [NREQ-1:0]   req;
  logic [NREQ*N-1:0] req_data;
  logic [NREQ-1:0]   ack;
  logic              tx_start;
  logic [N-1:0]      tx_data;
  logic              tx_done;
  logic              busy;
  logic [IDXW-1:0]   gnt_idx;
  logic              timeout_err;

  modport slave (
    input  req, req_data, tx_done,
    output ack, tx_start, tx_data, busy, gnt_idx, timeout_err
  );

  modport master (
    output req, req_data, tx_done,
    input  ack, tx_start, tx_data, busy, gnt_idx, timeout_err
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART transmitter among NREQ producers.
// Optional WAIT_DONE watchdog: define UART_TX_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
  parameter int NREQ    = 4,
  parameter int N       = 8,
  parameter int IDXW    = 2,
  parameter int TOW     = 16,
  parameter int TIMEOUT = 2000
) (
  input logic           clk,
  input logic           nrst,
  uart_tx_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [IDXW-1:0] ptr_q, ptr_d;
  logic [IDXW-1:0] gnt_q, gnt_d;
  logic [N-1:0]    data_q, data_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic            start_q, start_d;
  logic            busy_q, busy_d;
  logic            terr_q, terr_d;

  logic            hit;
  logic [IDXW-1:0] win;

  // Search starts just after the last winner and wraps at NREQ,
  // so unused indices of a non-power-of-two NREQ are never visited.
  always_comb begin
    hit = 1'b0;
    win = '0;
    for (int off = 1; off <= NREQ; off++) begin
      int j;
      j = int'(ptr_q) + off;
      if (j >= NREQ) j = j - NREQ;
      if (!hit && bus.req[j]) begin
        hit = 1'b1;
        win = IDXW'(j);
      end
    end
  end

`ifdef UART_TX_ARB_TIMEOUT_EN
  logic [TOW-1:0] cnt_q, cnt_d;
  logic           expire;

  assign expire = (cnt_q == TOW'(TIMEOUT - 1));
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    data_d  = data_q;
    ack_d   = '0;
    start_d = 1'b0;
    busy_d  = busy_q;
    terr_d  = 1'b0;
`ifdef UART_TX_ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (hit) begin
          state_d    = START;
          ptr_d      = win;
          gnt_d      = win;
          data_d     = bus.req_data[int'(win)*N +: N];
          ack_d[win] = 1'b1;
          start_d    = 1'b1;
          busy_d     = 1'b1;
        end
      end
      START: begin
        state_d = WAIT_DONE;
`ifdef UART_TX_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      WAIT_DONE: begin
        if (bus.tx_done) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
`ifdef UART_TX_ARB_TIMEOUT_EN
        else if (expire) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          terr_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
      ptr_q   <= IDXW'(NREQ - 1);
      gnt_q   <= '0;
      data_q  <= '0;
      ack_q   <= '0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      data_q  <= data_d;
      ack_q   <= ack_d;
      start_q <= start_d;
      busy_q  <= busy_d;
      terr_q  <= terr_d;
    end
  end

`ifdef UART_TX_ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign bus.timeout_err = terr_q;
`else
  assign bus.timeout_err = 1'b0;
`endif

  assign bus.ack      = ack_q;
  assign bus.tx_start = start_q;
  assign bus.tx_data  = data_q;
  assign bus.busy     = busy_q;
  assign bus.gnt_idx  = gnt_q;

endmodule
